// File: rtl/gerador_passos.sv
// gerador_passos
// Turns raw operator buttons into clean single-cycle step pulses (vai/vem)
// and a centring load request (set_pos/D) for contador_vai_vem.
// Each button is synchronised, a direction is debounced, and the first step
// is followed by hold-to-repeat auto-stepping.
// Pulses are masked at the counter end-stops. The PASSO cycle itself still
// happens, so the repeat timing keeps running.
//
// Ports
//   clock         system clock, rising edge
//   zera_s        synchronous active-high reset
//   botao_vai     raw button, step up
//   botao_vem     raw button, step down
//   botao_centro  raw button, jump to CENTRO
//   enable_mov    permits stepping; low forces idle
//   fim           counter at maximum
//   pos           counter position (0 = minimum)
//   vai / vem     one-cycle step pulses
//   set_pos       one-cycle load pulse
//   D             load value (constant CENTRO)
//   repetindo     high while auto-repeating
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_OCIOSO   | idle, waiting for a direction or the centre button
// S_DEBOUNCE | direction must stay stable for DEBOUNCE cycles
// S_PASSO    | one-cycle step emission
// S_ESPERA   | holding; counting to the next repeat step
// S_CENTRO   | one-cycle load of CENTRO into the counter
// S_SOLTA    | waits until every button is released

module gerador_passos #(
    parameter int N           = 7,
    parameter int CENTRO      = 49,
    parameter int DEBOUNCE    = 1000000,
    parameter int ATRASO_REP  = 25000000,
    parameter int PERIODO_REP = 5000000,
    parameter int CW          = 25
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         botao_vai,
    input  logic         botao_vem,
    input  logic         botao_centro,
    input  logic         enable_mov,
    input  logic         fim,
    input  logic [N-1:0] pos,
    output logic         vai,
    output logic         vem,
    output logic         set_pos,
    output logic [N-1:0] D,
    output logic         repetindo
);

    typedef enum logic [2:0] {
        S_OCIOSO,
        S_DEBOUNCE,
        S_PASSO,
        S_ESPERA,
        S_CENTRO,
        S_SOLTA
    } estado_t;

    typedef enum logic [1:0] {
        D_NENHUM,
        D_VAI,
        D_VEM
    } dir_t;

    localparam logic [CW-1:0] LIM_DEB = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] LIM_ATR = CW'(ATRASO_REP - 1);
    localparam logic [CW-1:0] LIM_PER = CW'(PERIODO_REP - 1);

    logic          r_vai_m, r_vai_s;
    logic          r_vem_m, r_vem_s;
    logic          r_centro_m, r_centro_s;
    estado_t       r_estado, w_prox_estado;
    dir_t          r_dir, w_prox_dir;
    logic [CW-1:0] r_cnt, w_prox_cnt;
    logic          r_rep, w_prox_rep;
    dir_t          w_req;
    logic          w_mantem;

    always_ff @(posedge clock) begin
        if (zera_s) begin
            r_vai_m    <= 1'b0;
            r_vai_s    <= 1'b0;
            r_vem_m    <= 1'b0;
            r_vem_s    <= 1'b0;
            r_centro_m <= 1'b0;
            r_centro_s <= 1'b0;
            r_estado   <= S_OCIOSO;
            r_dir      <= D_NENHUM;
            r_cnt      <= '0;
            r_rep      <= 1'b0;
        end else begin
            r_vai_m    <= botao_vai;
            r_vai_s    <= r_vai_m;
            r_vem_m    <= botao_vem;
            r_vem_s    <= r_vem_m;
            r_centro_m <= botao_centro;
            r_centro_s <= r_centro_m;
            r_estado   <= w_prox_estado;
            r_dir      <= w_prox_dir;
            r_cnt      <= w_prox_cnt;
            r_rep      <= w_prox_rep;
        end
    end

    always_comb begin
        w_req         = D_NENHUM;
        w_prox_estado = r_estado;
        w_prox_dir    = r_dir;
        w_prox_cnt    = r_cnt;
        w_prox_rep    = r_rep;

        // Both directions pressed together deliberately count as no request.
        if (r_vai_s && !r_vem_s)
            w_req = D_VAI;
        else if (r_vem_s && !r_vai_s)
            w_req = D_VEM;

        w_mantem = (w_req == r_dir) && enable_mov;

        case (r_estado)
            S_OCIOSO: begin
                w_prox_rep = 1'b0;
                if (r_centro_s) begin
                    w_prox_estado = S_CENTRO;
                end else if (enable_mov && (w_req != D_NENHUM)) begin
                    w_prox_dir    = w_req;
                    w_prox_cnt    = '0;
                    w_prox_estado = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!w_mantem)
                    w_prox_estado = S_OCIOSO;
                else if (r_cnt == LIM_DEB)
                    w_prox_estado = S_PASSO;
                else
                    w_prox_cnt = r_cnt + CW'(1);
            end
            S_PASSO: begin
                w_prox_cnt = '0;
                if (w_mantem) begin
                    w_prox_estado = S_ESPERA;
                end else begin
                    w_prox_estado = S_OCIOSO;
                    w_prox_rep    = 1'b0;
                end
            end
            S_ESPERA: begin
                if (!w_mantem) begin
                    w_prox_estado = S_OCIOSO;
                    w_prox_rep    = 1'b0;
                end else if (r_cnt == (r_rep ? LIM_PER : LIM_ATR)) begin
                    w_prox_estado = S_PASSO;
                    w_prox_rep    = 1'b1;
                end else begin
                    w_prox_cnt = r_cnt + CW'(1);
                end
            end
            S_CENTRO: begin
                w_prox_estado = S_SOLTA;
            end
            S_SOLTA: begin
                // A button held through the centring must be released before
                // anything else can be started.
                if (!r_vai_s && !r_vem_s && !r_centro_s)
                    w_prox_estado = S_OCIOSO;
            end
            default: begin
                w_prox_estado = S_OCIOSO;
            end
        endcase
    end

    assign vai       = (r_estado == S_PASSO) && (r_dir == D_VAI) && !fim;
    assign vem       = (r_estado == S_PASSO) && (r_dir == D_VEM) && (pos != '0);
    assign set_pos   = (r_estado == S_CENTRO);
    assign D         = N'(CENTRO);
    assign repetindo = r_rep;

endmodule

// File: tb/tb_gerador_passos.sv
module tb_gerador_passos;

    logic       clock = 1'b0;
    logic       zera_s;
    logic       botao_vai, botao_vem, botao_centro;
    logic       enable_mov, fim;
    logic [6:0] pos;
    logic       vai, vem, set_pos, repetindo;
    logic [6:0] D;

    int n_pass  = 0;
    int n_total = 0;
    int q_vai[$];
    int q_vem[$];

    gerador_passos #(
        .N(7), .CENTRO(49), .DEBOUNCE(4), .ATRASO_REP(10), .PERIODO_REP(3), .CW(25)
    ) dut (
        .clock(clock), .zera_s(zera_s),
        .botao_vai(botao_vai), .botao_vem(botao_vem), .botao_centro(botao_centro),
        .enable_mov(enable_mov), .fim(fim), .pos(pos),
        .vai(vai), .vem(vem), .set_pos(set_pos), .D(D), .repetindo(repetindo)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    endtask

    function automatic logic em(input int k, input int q[$]);
        em = 1'b0;
        foreach (q[i]) if (q[i] == k) em = 1'b1;
    endfunction

    task automatic pulsos(input string tag, input int k, input logic ev, input logic ew,
                          input logic es);
        check({tag, "_vai"}, k, {31'b0, vai}, {31'b0, ev});
        check({tag, "_vem"}, k, {31'b0, vem}, {31'b0, ew});
        check({tag, "_set"}, k, {31'b0, set_pos}, {31'b0, es});
    endtask

    initial begin
        zera_s = 1'b1;
        botao_vai = 1'b1; botao_vem = 1'b1; botao_centro = 1'b1;
        enable_mov = 1'b1; fim = 1'b0; pos = 7'd60;

        // reset held two edges with every button pressed
        for (int k = 1; k <= 2; k++) begin
            tick();
            pulsos("reset", k, 1'b0, 1'b0, 1'b0);
            check("reset_rep", k, {31'b0, repetindo}, 0);
            check("reset_D", k, {25'b0, D}, 49);
        end
        zera_s = 1'b0;
        botao_vai = 1'b0; botao_vem = 1'b0; botao_centro = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            pulsos("pos_reset", k, 1'b0, 1'b0, 1'b0);
        end

        // tap and hold vai: first step, delayed repeat, then periodic repeats
        q_vai = '{7, 18, 22, 26, 30, 34, 38};
        botao_vai = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            pulsos("hold_vai", k, em(k, q_vai), 1'b0, 1'b0);
            check("hold_rep", k, {31'b0, repetindo}, {31'b0, (k >= 18 && k <= 41)});
            if (k == 39) botao_vai = 1'b0;
        end

        // bounced vem never completes the debounce
        botao_vem = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            pulsos("bounce", k, 1'b0, 1'b0, 1'b0);
            botao_vem = ((k + 1) <= 3) || ((k + 1) >= 5 && (k + 1) <= 7);
        end

        // steady 8-cycle vem gives exactly one step
        botao_vem = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            pulsos("steady_vem", k, 1'b0, (k == 7), 1'b0);
            if (k == 8) botao_vem = 1'b0;
        end

        // vai at the top end-stop: masked, but repeat mode still engages
        fim = 1'b1;
        botao_vai = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            pulsos("fim_vai", k, 1'b0, 1'b0, 1'b0);
            check("fim_rep", k, {31'b0, repetindo}, {31'b0, (k >= 18)});
        end
        botao_vai = 1'b0;
        idle(8);
        fim = 1'b0;
        check("fim_rep_clr", 0, {31'b0, repetindo}, 0);

        // vem at the bottom end-stop, position leaves zero mid-repeat
        pos = 7'd0;
        q_vem = '{22, 26};
        botao_vem = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            pulsos("pos0_vem", k, 1'b0, em(k, q_vem), 1'b0);
            if (k == 20) pos = 7'd5;
            if (k == 27) botao_vem = 1'b0;
        end
        pos = 7'd60;

        // centre pulse while movement is disabled
        enable_mov = 1'b0;
        botao_centro = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            pulsos("centro", k, 1'b0, 1'b0, (k == 3));
            if (k == 3) check("centro_D", k, {25'b0, D}, 49);
            if (k == 1) botao_centro = 1'b0;
        end
        enable_mov = 1'b1;

        // vai pressed while centre still held: blocked until all released
        botao_centro = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            pulsos("centro_bloq", k, 1'b0, 1'b0, (k == 3));
            if (k == 4) botao_vai = 1'b1;
            if (k == 10) botao_centro = 1'b0;
        end
        botao_vai = 1'b0;
        idle(5);
        botao_vai = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            pulsos("apos_centro", k, (k == 7), 1'b0, 1'b0);
            if (k == 8) botao_vai = 1'b0;
        end
        idle(4);

        // both directions together
        botao_vai = 1'b1;
        botao_vem = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            pulsos("ambos", k, 1'b0, 1'b0, 1'b0);
            if (k == 12) begin
                botao_vai = 1'b0;
                botao_vem = 1'b0;
            end
        end
        idle(3);

        // enable dropped while waiting in repeat mode
        q_vai = '{7, 18};
        botao_vai = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            pulsos("enable_off", k, em(k, q_vai), 1'b0, 1'b0);
            check("enable_rep", k, {31'b0, repetindo}, {31'b0, (k >= 18 && k <= 20)});
            if (k == 20) enable_mov = 1'b0;
        end
        botao_vai = 1'b0;
        idle(5);
        enable_mov = 1'b1;

        // reset during debounce aborts the pending step
        botao_vai = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            pulsos("reset_deb", k, 1'b0, 1'b0, 1'b0);
            check("reset_deb_rep", k, {31'b0, repetindo}, 0);
            if (k == 5) zera_s = 1'b1;
            if (k == 6) begin
                zera_s = 1'b0;
                botao_vai = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
